// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide stall unit: operation
// encodings, FSM states and the default datapath width.
package md_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage : md_pkg

// File: rtl/md_stall_unit_if.sv
// Bundle between the EX stage and the multiply/divide unit. The unit is
// the slave side; the pipeline (or a bench) drives the master side.
interface md_stall_unit_if #(
    parameter int WIDTH = md_pkg::MD_WIDTH
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             mf_req_i;
    logic             hi_we_i;
    logic             lo_we_i;
    logic [WIDTH-1:0] mt_data_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             stall_o;

    modport slave (
        input  start_i, op_i, rs_i, rt_i, mf_req_i, hi_we_i, lo_we_i, mt_data_i,
        output hi_o, lo_o, busy_o, stall_o
    );

    modport master (
        output start_i, op_i, rs_i, rt_i, mf_req_i, hi_we_i, lo_we_i, mt_data_i,
        input  hi_o, lo_o, busy_o, stall_o
    );
endinterface : md_stall_unit_if

// File: rtl/md_iter_core.sv
// One radix-2 iteration of the multiply/divide datapath. The accumulator
// holds {upper, lower} halves: for multiply the partial product and the
// remaining multiplier bits, for divide the partial remainder and the
// quotient being shifted in from the right.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,   // multiplicand or divisor
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Shift-add multiply step or restoring divide step.
    always_comb begin
        sum_s     = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                  + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
        shifted_s = acc_i[2*WIDTH-1:WIDTH-1];
        trial_s   = shifted_s - {1'b0, operand_i};
        if (is_div_i) begin
            // Non-negative trial difference means the divisor fits: keep it.
            if (trial_s[WIDTH] == 1'b0) begin
                acc_o = {trial_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {shifted_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry of the add becomes the top product bit after the shift.
            acc_o = {sum_s, acc_i[WIDTH-1:1]};
        end
    end

endmodule : md_iter_core

// File: rtl/md_stall_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO. Operands are taken
// as magnitudes, iterated one bit per cycle, and the sign is restored in a
// final FIX cycle. stall_o freezes the pipeline while an instruction needs
// this unit or HI/LO during an operation.
module md_stall_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    md_stall_unit_if.slave  bus
);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_1  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_N  = CNT_W'(WIDTH);

    md_state_e          state_r, state_s;
    logic [2*WIDTH-1:0] acc_r, acc_s, core_acc_s;
    logic [WIDTH-1:0]   opnd_r, opnd_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               div_r, div_s;
    logic               neg_q_r, neg_q_s;     // quotient / product negative
    logic               neg_r_r, neg_r_s;     // remainder negative
    logic               dz_r, dz_s;           // divide by zero
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;
    logic               busy_r, busy_s;

    md_op_e             op_s;
    logic               sgn_s;
    logic [WIDTH-1:0]   abs_rs_s, abs_rt_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [2*WIDTH-1:0] prod_s;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .acc_i     (acc_r),
        .operand_i (opnd_r),
        .is_div_i  (div_r),
        .acc_o     (core_acc_s)
    );

    // Operand decode: magnitudes for the signed ops, raw values otherwise.
    always_comb begin
        op_s     = md_op_e'(bus.op_i);
        sgn_s    = (op_s == MD_MULT) || (op_s == MD_DIV);
        abs_rs_s = (sgn_s && bus.rs_i[WIDTH-1]) ? (~bus.rs_i + ONE_W) : bus.rs_i;
        abs_rt_s = (sgn_s && bus.rt_i[WIDTH-1]) ? (~bus.rt_i + ONE_W) : bus.rt_i;
    end

    // Result sign correction applied in FIX.
    always_comb begin
        quo_s  = neg_q_r ? (~acc_r[WIDTH-1:0] + ONE_W) : acc_r[WIDTH-1:0];
        rem_s  = neg_r_r ? (~acc_r[2*WIDTH-1:WIDTH] + ONE_W) : acc_r[2*WIDTH-1:WIDTH];
        prod_s = neg_q_r ? (~acc_r + ONE_2W) : acc_r;
    end

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        opnd_s  = opnd_r;
        cnt_s   = cnt_r;
        div_s   = div_r;
        neg_q_s = neg_q_r;
        neg_r_s = neg_r_r;
        dz_s    = dz_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    // Start wins over a simultaneous MTHI/MTLO.
                    div_s   = bus.op_i[1];
                    neg_q_s = sgn_s && (bus.rs_i[WIDTH-1] ^ bus.rt_i[WIDTH-1]);
                    neg_r_s = sgn_s && bus.rs_i[WIDTH-1];
                    cnt_s   = CNT_N;
                    if (bus.op_i[1] && (bus.rt_i == {WIDTH{1'b0}})) begin
                        // Keep the raw dividend for HI.
                        dz_s    = 1'b1;
                        acc_s   = {{WIDTH{1'b0}}, bus.rs_i};
                        opnd_s  = {WIDTH{1'b0}};
                        state_s = FIX;
                    end else if (bus.op_i[1]) begin
                        dz_s    = 1'b0;
                        acc_s   = {{WIDTH{1'b0}}, abs_rs_s};
                        opnd_s  = abs_rt_s;
                        state_s = CALC;
                    end else begin
                        dz_s    = 1'b0;
                        acc_s   = {{WIDTH{1'b0}}, abs_rt_s};
                        opnd_s  = abs_rs_s;
                        state_s = CALC;
                    end
                end else begin
                    if (bus.hi_we_i) begin
                        hi_s = bus.mt_data_i;
                    end else begin
                        hi_s = hi_r;
                    end
                    if (bus.lo_we_i) begin
                        lo_s = bus.mt_data_i;
                    end else begin
                        lo_s = lo_r;
                    end
                end
            end
            CALC: begin
                acc_s = core_acc_s;
                cnt_s = cnt_r - CNT_1;
                if (cnt_r == CNT_1) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                state_s = IDLE;
                if (dz_r) begin
                    lo_s = {WIDTH{1'b1}};
                    hi_s = acc_r[WIDTH-1:0];
                end else if (div_r) begin
                    lo_s = quo_s;
                    hi_s = rem_s;
                end else begin
                    {hi_s, lo_s} = prod_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            acc_r   <= {(2*WIDTH){1'b0}};
            opnd_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            div_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            opnd_r  <= opnd_s;
            cnt_r   <= cnt_s;
            div_r   <= div_s;
            neg_q_r <= neg_q_s;
            neg_r_r <= neg_r_s;
            dz_r    <= dz_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.hi_o    = hi_r;
    assign bus.lo_o    = lo_r;
    assign bus.busy_o  = busy_r;
    // Combinational so the requesting instruction is frozen in the same cycle.
    assign bus.stall_o = busy_r & (bus.start_i | bus.mf_req_i | bus.hi_we_i | bus.lo_we_i);

endmodule : md_stall_unit

// File: tb/tb_md_stall_unit.sv
// Directed bench for md_stall_unit with hand-computed expected results.
module tb_md_stall_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   bcnt;

    md_stall_unit_if #(.WIDTH(W)) bus_if ();

    md_stall_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op for one cycle, then count negedges while busy_o is high.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                         output int busy_cycles);
        bus_if.start_i = 1'b1;
        bus_if.op_i    = op;
        bus_if.rs_i    = rs;
        bus_if.rt_i    = rt;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        bus_if.rs_i    = 32'hA5A5_A5A5;
        bus_if.rt_i    = 32'h0000_0003;
        busy_cycles = 0;
        while (bus_if.busy_o && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic op_case(input string tag, input logic [1:0] op, input logic [W-1:0] rs,
                           input logic [W-1:0] rt, input int exp_busy,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int b;
        do_op(op, rs, rt, b);
        check_eq({tag, "_busy"}, 64'(b), 64'(exp_busy));
        check_eq({tag, "_hi"}, 64'(bus_if.hi_o), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(bus_if.lo_o), 64'(exp_lo));
    endtask

    initial begin
        bus_if.start_i   = 1'b0;
        bus_if.op_i      = 2'b00;
        bus_if.rs_i      = '0;
        bus_if.rt_i      = '0;
        bus_if.mf_req_i  = 1'b0;
        bus_if.hi_we_i   = 1'b0;
        bus_if.lo_we_i   = 1'b0;
        bus_if.mt_data_i = '0;

        #2;
        check_eq("rst_hi", 64'(bus_if.hi_o), 64'h0);
        check_eq("rst_lo", 64'(bus_if.lo_o), 64'h0);
        check_eq("rst_busy", 64'(bus_if.busy_o), 64'h0);
        check_eq("rst_stall", 64'(bus_if.stall_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // MULTU 7*6: no stall while idle even with start asserted
        bus_if.start_i = 1'b1;
        #1;
        check_eq("idle_start_stall", 64'(bus_if.stall_o), 64'h0);
        bus_if.start_i = 1'b0;
        op_case("multu_7x6", MD_MULTU, 32'd7, 32'd6, 33, 32'h0, 32'd42);
        op_case("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        op_case("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        op_case("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_case("div_7dm2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        op_case("divu_100d7", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        op_case("divu_dz", MD_DIVU, 32'h1234, 32'h0, 1, 32'h1234, 32'hFFFF_FFFF);
        op_case("div_dz", MD_DIV, 32'h0000_0042, 32'h0, 1, 32'h0000_0042, 32'hFFFF_FFFF);
        op_case("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

        // MULT 1000*-2 with MFHI/MFLO waiting from cycle 2 and a stray start mid-op
        bus_if.start_i = 1'b1;
        bus_if.op_i    = MD_MULT;
        bus_if.rs_i    = 32'd1000;
        bus_if.rt_i    = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int k = 1; k <= 34; k++) begin
            bus_if.mf_req_i = (k >= 2);
            bus_if.start_i  = (k == 5) || (k == 6);
            bus_if.op_i     = MD_DIVU;
            bus_if.rs_i     = 32'h999;
            bus_if.rt_i     = 32'h0;
            #1;
            if (k <= 33) begin
                check_eq($sformatf("mf_busy_%0d", k), 64'(bus_if.busy_o), 64'h1);
                check_eq($sformatf("mf_stall_%0d", k), 64'(bus_if.stall_o), (k >= 2) ? 64'h1 : 64'h0);
            end else begin
                check_eq("mf_end_busy", 64'(bus_if.busy_o), 64'h0);
                check_eq("mf_end_stall", 64'(bus_if.stall_o), 64'h0);
                check_eq("mf_end_hi", 64'(bus_if.hi_o), 64'hFFFF_FFFF);
                check_eq("mf_end_lo", 64'(bus_if.lo_o), 64'hFFFF_F830);
            end
            @(negedge clk);
        end
        bus_if.mf_req_i = 1'b0;
        #1;
        check_eq("stray_start_busy", 64'(bus_if.busy_o), 64'h0);
        check_eq("stray_start_lo", 64'(bus_if.lo_o), 64'hFFFF_F830);

        // Reset between clock edges in the middle of CALC
        bus_if.start_i = 1'b1;
        bus_if.op_i    = MD_MULTU;
        bus_if.rs_i    = 32'd7;
        bus_if.rt_i    = 32'd6;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.mf_req_i = 1'b1;
        #1;
        check_eq("pre_rst_stall", 64'(bus_if.stall_o), 64'h1);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_hi", 64'(bus_if.hi_o), 64'h0);
        check_eq("mid_rst_lo", 64'(bus_if.lo_o), 64'h0);
        check_eq("mid_rst_busy", 64'(bus_if.busy_o), 64'h0);
        check_eq("mid_rst_stall", 64'(bus_if.stall_o), 64'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("post_rst_busy", 64'(bus_if.busy_o), 64'h0);
        check_eq("post_rst_mf_stall", 64'(bus_if.stall_o), 64'h0);
        bus_if.mf_req_i = 1'b0;

        // MTLO then MFLO
        @(negedge clk);
        bus_if.lo_we_i   = 1'b1;
        bus_if.mt_data_i = 32'h55;
        @(negedge clk);
        bus_if.lo_we_i  = 1'b0;
        bus_if.mf_req_i = 1'b1;
        #1;
        check_eq("mtlo_lo", 64'(bus_if.lo_o), 64'h55);
        check_eq("mtlo_hi", 64'(bus_if.hi_o), 64'h0);
        check_eq("mflo_stall", 64'(bus_if.stall_o), 64'h0);
        bus_if.mf_req_i = 1'b0;

        // MTHI and MTLO together write both
        @(negedge clk);
        bus_if.hi_we_i   = 1'b1;
        bus_if.lo_we_i   = 1'b1;
        bus_if.mt_data_i = 32'hAA;
        @(negedge clk);
        bus_if.hi_we_i = 1'b0;
        bus_if.lo_we_i = 1'b0;
        #1;
        check_eq("mt_both_hi", 64'(bus_if.hi_o), 64'hAA);
        check_eq("mt_both_lo", 64'(bus_if.lo_o), 64'hAA);

        // Start beats a simultaneous MTHI
        @(negedge clk);
        bus_if.hi_we_i   = 1'b1;
        bus_if.mt_data_i = 32'hDEAD;
        bus_if.start_i   = 1'b1;
        bus_if.op_i      = MD_MULTU;
        bus_if.rs_i      = 32'd2;
        bus_if.rt_i      = 32'd3;
        @(negedge clk);
        bus_if.hi_we_i = 1'b0;
        bus_if.start_i = 1'b0;
        #1;
        check_eq("start_wins_hi_held", 64'(bus_if.hi_o), 64'hAA);
        bcnt = 0;
        while (bus_if.busy_o && bcnt < 100) begin
            bcnt++;
            @(negedge clk);
        end
        #1;
        check_eq("start_wins_busy", 64'(bcnt), 64'd33);
        check_eq("start_wins_hi", 64'(bus_if.hi_o), 64'h0);
        check_eq("start_wins_lo", 64'(bus_if.lo_o), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_md_stall_unit
